// File: rtl/demux_1to4_stream_pkg.sv
// demux_pkg: shared types and helpers for the 1:4 stream demultiplexer
package demux_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] ch_sel_t;
    typedef enum logic {ST_EMPTY, ST_FULL} dmx_state_t;
    function automatic logic [NUM_CH-1:0] onehot4(ch_sel_t s);
        return 4'b0001 << s;
    endfunction
endpackage

// File: rtl/demux_1to4_stream_sat_counter.sv
// sat_counter: synchronous-clear beat counter that sticks at its maximum value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        if (clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1:4 valid/ready demux with per-channel saturating beat counters
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [1:0]              in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat,
    input  logic                    cnt_clr
);
    dmx_state_t        state;
    logic [DATA_W-1:0] data_q;
    ch_sel_t           sel_q;
    logic              hit;
    logic              accept;
    logic [NUM_CH-1:0] fire;
    assign hit       = (state == ST_FULL) && out_ready[sel_q];
    // only the selected consumer's ready reaches the producer, so a full slot drains and refills in one cycle
    assign in_ready  = !rst && ((state == ST_EMPTY) || out_ready[sel_q]);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL) ? onehot4(sel_q) : '0;
    assign out_data  = data_q;
    assign fire      = out_valid & out_ready;
    always_ff @(posedge clk)
        if (rst) begin
            state  <= ST_EMPTY;
            data_q <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            state  <= ST_FULL;
            data_q <= in_data;
            sel_q  <= in_sel;
        end else if (hit) begin
            state  <= ST_EMPTY;
        end
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .clr (rst || cnt_clr),
            .inc (fire[k]),
            .cnt (cnt_flat[k*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb_demux_1to4_stream: directed self-checking bench; a second instance with 2-bit counters exercises saturation
module tb_demux_1to4_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_ready = '0;
    logic        cnt_clr = 1'b0;
    logic        in_ready, in_ready_s;
    logic [3:0]  out_valid, out_valid_s;
    logic [7:0]  out_data, out_data_s;
    logic [63:0] cnt_flat;
    logic [7:0]  cnt_flat_s;
    int n_cmp = 0;
    int n_err = 0;

    demux_1to4_stream #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .cnt_flat(cnt_flat),
        .cnt_clr(cnt_clr)
    );

    demux_1to4_stream #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .cnt_flat(cnt_flat_s),
        .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt(input int k);
        return cnt_flat[k*16 +: 16];
    endfunction

    initial begin
        // reset and idle
        tick();
        chk("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_out_valid", out_valid, 4'b0000);
        chk("idle_out_data", out_data, 8'h00);
        chk("idle_cnt", cnt_flat, 64'd0);
        chk("idle_in_ready", in_ready, 1);

        // single beat
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2; out_ready = 4'hF;
        tick();
        in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0;
        #1;
        chk("single_out_valid", out_valid, 4'b0100);
        chk("single_out_data", out_data, 8'hA5);
        tick();
        chk("single_cnt2", cnt(2), 16'd1);
        chk("single_drained", out_valid, 4'b0000);

        // streaming, counters cleared first
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", cnt_flat, 64'd0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i); in_sel = 2'(i % 4);
            #1;
            chk($sformatf("stream_in_ready%0d", i), in_ready, 1);
            if (i > 0) begin
                chk($sformatf("stream_valid%0d", i), out_valid, 4'b0001 << ((i - 1) % 4));
                chk($sformatf("stream_data%0d", i), out_data, 8'h10 + 8'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("stream_last_valid", out_valid, 4'b1000);
        chk("stream_last_data", out_data, 8'h17);
        tick();
        chk("stream_cnt", cnt_flat, {16'd2, 16'd2, 16'd2, 16'd2});

        // backpressure on channel 1; other channels ready but must be ignored
        in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd1; out_ready = 4'b1101; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; in_data = 8'h99; in_sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_valid%0d", i), out_valid, 4'b0010);
            chk($sformatf("bp_data%0d", i), out_data, 8'h3C);
            chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 4'b0010;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_drained", out_valid, 4'b0000);
        chk("bp_cnt", cnt_flat, {16'd0, 16'd0, 16'd1, 16'd0});

        // saturation with 2-bit counters, then clear coincident with a handshake
        out_ready = 4'hF; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i); in_sel = 2'd3;
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("sat_last_valid", out_valid_s, 4'b1000);
        chk("sat_last_data", out_data_s, 8'h44);
        tick();
        chk("sat_cnt3", cnt_flat_s[7:6], 2'd3);
        chk("sat_others", cnt_flat_s[5:0], 6'd0);
        chk("wide_cnt3", cnt(3), 16'd5);
        in_valid = 1'b1; in_data = 8'h55; in_sel = 2'd3;
        tick();
        in_valid = 1'b0; cnt_clr = 1'b1;
        #1;
        chk("clr_hs_valid", out_valid_s, 4'b1000);
        tick();
        cnt_clr = 1'b0;
        chk("clr_hs_sat_cnt3", cnt_flat_s, 8'd0);
        chk("clr_hs_wide_cnt3", cnt(3), 16'd0);
        chk("clr_hs_drained", out_valid, 4'b0000);

        // reset while a beat is held
        in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd0; out_ready = 4'b1110;
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_full_valid", out_valid, 4'b0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        chk("mid_rst_valid", out_valid, 4'b0000);
        chk("mid_rst_data", out_data, 8'h00);
        rst = 1'b0; out_ready = 4'hF;
        tick();
        chk("post_rst_valid", out_valid, 4'b0000);
        chk("post_rst_cnt", cnt_flat, 64'd0);
        chk("post_rst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
